// File: rtl/float_sub.sv
// float_sub: IEEE-754 binary32 subtractor, z = a - b.
//
// One operation is in flight at a time. Operands arrive over separate
// stb/ack channels (a first, then b); the result leaves on a third.
// The datapath shifts one bit per cycle, so each operation takes many cycles.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous, active-high reset
//   input_a       operand a      input_a_stb  a valid    input_a_ack  a accepted
//   input_b       operand b      input_b_stb  b valid    input_b_ack  b accepted
//   output_z      result a - b   output_z_stb z valid    output_z_ack z consumed
module float_sub (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORMALISE, ROUND, PACK, PUT
  } state_t;

  localparam logic [31:0]       QNAN = 32'h7FC0_0000;
  localparam logic signed [9:0] EMIN = -10'sd126;

  state_t state_q, state_d;

  logic        input_a_ack_q, input_a_ack_d;
  logic        input_b_ack_q, input_b_ack_d;
  logic        output_z_stb_q, output_z_stb_d;
  logic [31:0] output_z_q, output_z_d;

  // b is stored with its sign already flipped, so the rest is an addition.
  logic [31:0]       a_q, a_d, b_q, b_d;
  // Mantissas: bit 26 hidden, 25..3 fraction, 2 guard, 1 round, 0 sticky.
  logic [26:0]       a_m_q, a_m_d, b_m_q, b_m_d;
  logic signed [9:0] a_e_q, a_e_d, b_e_q, b_e_d, z_e_q, z_e_d;
  logic              a_s_q, a_s_d, b_s_q, b_s_d, z_s_q, z_s_d;
  logic [27:0]       sum_q, sum_d;
  logic [23:0]       z_m_q, z_m_d;
  logic              guard_q, guard_d, round_q, round_d, sticky_q, sticky_d;

  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic signed [9:0] exp_diff;

  assign a_nan    = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'd0);
  assign b_nan    = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);
  assign a_inf    = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'd0);
  assign b_inf    = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
  assign a_zero   = (a_q[30:0] == 31'd0);
  assign b_zero   = (b_q[30:0] == 31'd0);
  assign exp_diff = a_e_q - b_e_q;

  assign input_a_ack  = input_a_ack_q;
  assign input_b_ack  = input_b_ack_q;
  assign output_z     = output_z_q;
  assign output_z_stb = output_z_stb_q;

  always_comb begin
    state_d        = state_q;
    input_a_ack_d  = input_a_ack_q;
    input_b_ack_d  = input_b_ack_q;
    output_z_stb_d = output_z_stb_q;
    output_z_d     = output_z_q;
    a_d = a_q;  b_d = b_q;
    a_m_d = a_m_q;  b_m_d = b_m_q;
    a_e_d = a_e_q;  b_e_d = b_e_q;  z_e_d = z_e_q;
    a_s_d = a_s_q;  b_s_d = b_s_q;  z_s_d = z_s_q;
    sum_d = sum_q;  z_m_d = z_m_q;
    guard_d = guard_q;  round_d = round_q;  sticky_d = sticky_q;

    case (state_q)
      GET_A: begin
        input_a_ack_d = 1'b1;
        if (input_a_ack_q && input_a_stb) begin
          a_d           = input_a;
          input_a_ack_d = 1'b0;
          state_d       = GET_B;
        end
      end

      GET_B: begin
        input_b_ack_d = 1'b1;
        if (input_b_ack_q && input_b_stb) begin
          b_d           = {~input_b[31], input_b[30:0]};
          input_b_ack_d = 1'b0;
          state_d       = UNPACK;
        end
      end

      UNPACK: begin
        a_s_d = a_q[31];
        b_s_d = b_q[31];
        // Denormals sit at the minimum exponent with no hidden bit.
        if (a_q[30:23] == 8'd0) begin
          a_e_d = EMIN;
          a_m_d = {1'b0, a_q[22:0], 3'b000};
        end else begin
          a_e_d = $signed({2'b00, a_q[30:23]}) - 10'sd127;
          a_m_d = {1'b1, a_q[22:0], 3'b000};
        end
        if (b_q[30:23] == 8'd0) begin
          b_e_d = EMIN;
          b_m_d = {1'b0, b_q[22:0], 3'b000};
        end else begin
          b_e_d = $signed({2'b00, b_q[30:23]}) - 10'sd127;
          b_m_d = {1'b1, b_q[22:0], 3'b000};
        end
        state_d = SPECIAL;
      end

      SPECIAL: begin
        state_d = PUT;
        if (a_nan || b_nan) begin
          output_z_d = QNAN;
        end else if (a_inf && b_inf && (a_q[31] != b_q[31])) begin
          // Signs differ after flipping b: inf minus like-signed inf.
          output_z_d = QNAN;
        end else if (a_inf) begin
          output_z_d = a_q;
        end else if (b_inf) begin
          output_z_d = b_q;
        end else if (a_zero && b_zero) begin
          output_z_d = {a_q[31] & b_q[31], 31'd0};
        end else if (a_zero) begin
          output_z_d = b_q;
        end else if (b_zero) begin
          output_z_d = a_q;
        end else begin
          state_d = ALIGN;
        end
      end

      ALIGN: begin
        // Beyond 27 positions every bit lands in sticky, so collapse at once.
        if (a_e_q > b_e_q) begin
          if (exp_diff > 10'sd27) begin
            b_m_d = {26'd0, |b_m_q};
            b_e_d = a_e_q;
          end else begin
            b_m_d = {1'b0, b_m_q[26:2], b_m_q[1] | b_m_q[0]};
            b_e_d = b_e_q + 10'sd1;
          end
        end else if (a_e_q < b_e_q) begin
          if (exp_diff < -10'sd27) begin
            a_m_d = {26'd0, |a_m_q};
            a_e_d = b_e_q;
          end else begin
            a_m_d = {1'b0, a_m_q[26:2], a_m_q[1] | a_m_q[0]};
            a_e_d = a_e_q + 10'sd1;
          end
        end else begin
          state_d = ADD_0;
        end
      end

      ADD_0: begin
        if (a_s_q == b_s_q) begin
          sum_d = {1'b0, a_m_q} + {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else if (a_m_q >= b_m_q) begin
          sum_d = {1'b0, a_m_q} - {1'b0, b_m_q};
          z_s_d = a_s_q;
        end else begin
          sum_d = {1'b0, b_m_q} - {1'b0, a_m_q};
          z_s_d = b_s_q;
        end
        state_d = ADD_1;
      end

      ADD_1: begin
        if (sum_q[27]) begin
          z_m_d    = sum_q[27:4];
          guard_d  = sum_q[3];
          round_d  = sum_q[2];
          sticky_d = sum_q[1] | sum_q[0];
          z_e_d    = a_e_q + 10'sd1;
        end else begin
          z_m_d    = sum_q[26:3];
          guard_d  = sum_q[2];
          round_d  = sum_q[1];
          sticky_d = sum_q[0];
          z_e_d    = a_e_q;
        end
        state_d = NORMALISE;
      end

      NORMALISE: begin
        // An exact zero would otherwise walk all the way down to EMIN.
        if ((z_m_q == 24'd0) && !guard_q && !round_q && !sticky_q) begin
          state_d = ROUND;
        end else if (!z_m_q[23] && (z_e_q > EMIN)) begin
          z_m_d   = {z_m_q[22:0], guard_q};
          guard_d = round_q;
          round_d = 1'b0;
          z_e_d   = z_e_q - 10'sd1;
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        if (guard_q && (round_q || sticky_q || z_m_q[0])) begin
          if (z_m_q == 24'hFF_FFFF) begin
            z_m_d = 24'h80_0000;
            z_e_d = z_e_q + 10'sd1;
          end else begin
            z_m_d = z_m_q + 24'd1;
          end
        end
        state_d = PACK;
      end

      PACK: begin
        output_z_d = {z_s_q, z_e_q[7:0] + 8'd127, z_m_q[22:0]};
        if ((z_e_q == EMIN) && !z_m_q[23]) begin
          output_z_d[30:23] = 8'd0;
        end
        if (z_e_q > 10'sd127) begin
          output_z_d = {z_s_q, 8'hFF, 23'd0};
        end
        if (z_m_q == 24'd0) begin
          output_z_d = 32'd0;
        end
        state_d = PUT;
      end

      PUT: begin
        output_z_stb_d = 1'b1;
        if (output_z_stb_q && output_z_ack) begin
          output_z_stb_d = 1'b0;
          state_d        = GET_A;
        end
      end

      default: state_d = GET_A;
    endcase
  end

  // Control state and handshake flags; reset abandons any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= GET_A;
      input_a_ack_q  <= 1'b0;
      input_b_ack_q  <= 1'b0;
      output_z_stb_q <= 1'b0;
      output_z_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      input_a_ack_q  <= input_a_ack_d;
      input_b_ack_q  <= input_b_ack_d;
      output_z_stb_q <= output_z_stb_d;
      output_z_q     <= output_z_d;
    end
  end

  // Datapath registers are always rewritten before use, so they need no reset.
  always_ff @(posedge clk) begin
    a_q <= a_d;  b_q <= b_d;
    a_m_q <= a_m_d;  b_m_q <= b_m_d;
    a_e_q <= a_e_d;  b_e_q <= b_e_d;  z_e_q <= z_e_d;
    a_s_q <= a_s_d;  b_s_q <= b_s_d;  z_s_q <= z_s_d;
    sum_q <= sum_d;  z_m_q <= z_m_d;
    guard_q <= guard_d;  round_q <= round_d;  sticky_q <= sticky_d;
  end

endmodule

// File: tb/tb_float_sub.sv
// tb_float_sub: self-checking bench for float_sub.
// Directed vectors, handshake/backpressure/reset scenarios and random
// operands checked against an exact-arithmetic binary32 reference model.
module tb_float_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  int check_count = 0;
  int pass_count  = 0;

  float_sub dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .input_b      (input_b),
    .input_b_stb  (input_b_stb),
    .input_b_ack  (input_b_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  always #5 clk = ~clk;

  // Exact magnitude of a finite operand in units of 2^-149.
  function automatic logic [299:0] magOf(input logic [31:0] x);
    logic [299:0] sig;
    int           e;
    sig = '0;
    if (x[30:23] == 8'd0) begin
      sig[22:0] = x[22:0];
      e = 1;
    end else begin
      sig[23:0] = {1'b1, x[22:0]};
      e = int'(x[30:23]);
    end
    return sig << (e - 1);
  endfunction

  // Reference: exact a - b, then one round-to-nearest-even to binary32.
  function automatic logic [31:0] refSub(input logic [31:0] a, input logic [31:0] b);
    logic         sa, sb, s;
    logic         a_nan, b_nan, a_inf, b_inf;
    logic [299:0] ma, mb, mag, keep, rem, half, one;
    logic [7:0]   fe;
    int           p, shift, field;
    sa = a[31];
    sb = ~b[31];
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (a_nan || b_nan) return 32'h7FC0_0000;
    if (a_inf && b_inf) return (sa == sb) ? a : 32'h7FC0_0000;
    if (a_inf) return a;
    if (b_inf) return {sb, b[30:0]};
    if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
      return (a[31] && !b[31]) ? 32'h8000_0000 : 32'h0000_0000;
    if (a[30:0] == 31'd0) return {sb, b[30:0]};
    if (b[30:0] == 31'd0) return a;
    ma = magOf(a);
    mb = magOf(b);
    if (sa == sb) begin
      mag = ma + mb; s = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; s = sa;
    end else begin
      mag = mb - ma; s = sb;
    end
    if (mag == '0) return 32'h0000_0000;
    p = -1;
    for (int i = 299; i >= 0; i--) if (mag[i] && p < 0) p = i;
    if (p <= 23) return {s, 7'd0, mag[23:0]};
    shift = p - 23;
    one   = 300'd1;
    keep  = mag >> shift;
    rem   = mag & ((one << shift) - one);
    half  = one << (shift - 1);
    if ((rem > half) || ((rem == half) && keep[0])) keep = keep + one;
    if (keep[24]) begin
      keep  = keep >> 1;
      shift = shift + 1;
    end
    field = shift + 1;
    if (field >= 255) return {s, 8'hFF, 23'd0};
    fe = 8'(field);
    return {s, fe, keep[22:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s observed=%08h expected=%08h", tag, observed, expected);
  endtask

  // Pass a then b through their handshakes; ok drops if an ack never comes.
  task automatic sendOperands(input logic [31:0] a, input logic [31:0] b, output bit ok);
    int n;
    ok = 1'b1;
    input_a = a;
    input_a_stb = 1'b1;
    n = 0;
    while (input_a_ack !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) ok = 1'b0;
    tick();
    input_a_stb = 1'b0;
    input_b = b;
    input_b_stb = 1'b1;
    n = 0;
    while (input_b_ack !== 1'b1 && n < 200) begin tick(); n++; end
    if (n >= 200) ok = 1'b0;
    tick();
    input_b_stb = 1'b0;
  endtask

  task automatic waitResult(output int latency, output bit ok);
    latency = 0;
    while (output_z_stb !== 1'b1 && latency < 200) begin tick(); latency++; end
    ok = (output_z_stb === 1'b1);
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expected);
    bit ok_in, ok_out;
    int lat;
    sendOperands(a, b, ok_in);
    waitResult(lat, ok_out);
    checkOutput({tag, ":done"}, {31'd0, ok_in & ok_out}, 32'd1);
    if (ok_out) begin
      checkOutput(tag, output_z, expected);
      checkOutput({tag, ":latency"}, {31'd0, lat <= 65}, 32'd1);
    end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired observed=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          ok;
    bit          held;
    int          lat;
    logic [31:0] ra, rb;
    logic [7:0]  eb;

    rst = 1'b1;
    input_a = 32'd0; input_a_stb = 1'b0;
    input_b = 32'd0; input_b_stb = 1'b0;
    output_z_ack = 1'b0;
    tick();
    tick();
    checkOutput("rst_a_ack", {31'd0, input_a_ack}, 32'd0);
    checkOutput("rst_b_ack", {31'd0, input_b_ack}, 32'd0);
    checkOutput("rst_z_stb", {31'd0, output_z_stb}, 32'd0);
    checkOutput("rst_z", output_z, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("idle_a_ack", {31'd0, input_a_ack}, 32'd1);

    // b offered while waiting for a must not be accepted.
    input_b = 32'h3F80_0000;
    input_b_stb = 1'b1;
    tick();
    tick();
    checkOutput("b_in_get_a", {31'd0, input_b_ack}, 32'd0);
    input_b_stb = 1'b0;

    applyStimulus("basic",      32'h3F80_0000, 32'h3F00_0000, 32'h3F00_0000);
    applyStimulus("cancel",     32'h4040_0000, 32'h4040_0000, 32'h0000_0000);
    applyStimulus("neg_zero",   32'h8000_0000, 32'h0000_0000, 32'h8000_0000);
    applyStimulus("pos_zero",   32'h0000_0000, 32'h8000_0000, 32'h0000_0000);
    applyStimulus("inf_inf",    32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
    applyStimulus("nan",        32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
    applyStimulus("zero_ninf",  32'h0000_0000, 32'hFF80_0000, 32'h7F80_0000);
    applyStimulus("tie_even",   32'h3F80_0000, 32'hB380_0000, 32'h3F80_0000);
    applyStimulus("round_dn",   32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF);
    applyStimulus("denormal",   32'h0080_0000, 32'h0000_0001, 32'h007F_FFFF);
    applyStimulus("overflow",   32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000);
    applyStimulus("zero_minus", 32'h0000_0000, 32'h4120_0000, 32'hC120_0000);

    // Backpressure: result and valid must hold; a offered in PUT is ignored.
    sendOperands(32'h3F80_0000, 32'h3F00_0000, ok);
    waitResult(lat, ok);
    checkOutput("bp_ready", {31'd0, ok}, 32'd1);
    input_a = 32'h4000_0000;
    input_a_stb = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (output_z_stb !== 1'b1 || output_z !== 32'h3F00_0000 || input_a_ack !== 1'b0)
        held = 1'b0;
    end
    checkOutput("bp_hold", {31'd0, held}, 32'd1);
    checkOutput("bp_value", output_z, 32'h3F00_0000);
    input_a_stb = 1'b0;
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    checkOutput("bp_released", {31'd0, output_z_stb}, 32'd0);

    // Reset while aligning a 23-bit exponent gap abandons the operation.
    sendOperands(32'h4B00_0000, 32'h3F80_0000, ok);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("align_rst_z", output_z, 32'd0);
    tick();
    checkOutput("align_rst_stb", {31'd0, output_z_stb}, 32'd0);
    checkOutput("align_rst_a_ack", {31'd0, input_a_ack}, 32'd1);
    applyStimulus("post_reset", 32'h4B00_0000, 32'h3F80_0000, 32'h4AFF_FFFE);

    // Random operands: fully random, close exponents, and near-cancellation.
    for (int i = 0; i < 200; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 2))
        0: rb = $urandom;
        1: begin
          eb = ra[30:23] + 8'($urandom_range(0, 6)) - 8'd3;
          rb = {1'($urandom_range(0, 1)), eb, 23'($urandom)};
        end
        default: rb = {ra[31:8], 8'($urandom)};
      endcase
      applyStimulus("random", ra, rb, refSub(ra, rb));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
